// File: rtl/simon_pkg.sv
// Shared constants, scan FSM encoding and display image payload for the
// seven-segment scan controller.
package simon_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [7:0]  SEG_OFF    = 8'hFF;
  localparam logic [3:0]  ANODE_OFF  = 4'hF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  digit_en;
    logic [3:0]  dp;
  } image_t;

endpackage

// File: rtl/seven_seg.sv
// Hex nibble to active-low segment decoder, output ordered {g,f,e,d,c,b,a}.
module seven_seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_n_c
);

  always_comb begin
    seg_n_c = 7'h7F;
    unique case (hex_i)
      4'h0: seg_n_c = 7'h40;
      4'h1: seg_n_c = 7'h79;
      4'h2: seg_n_c = 7'h24;
      4'h3: seg_n_c = 7'h30;
      4'h4: seg_n_c = 7'h19;
      4'h5: seg_n_c = 7'h12;
      4'h6: seg_n_c = 7'h02;
      4'h7: seg_n_c = 7'h78;
      4'h8: seg_n_c = 7'h00;
      4'h9: seg_n_c = 7'h10;
      4'hA: seg_n_c = 7'h08;
      4'hB: seg_n_c = 7'h03;
      4'hC: seg_n_c = 7'h46;
      4'hD: seg_n_c = 7'h21;
      4'hE: seg_n_c = 7'h06;
      4'hF: seg_n_c = 7'h0E;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode scan controller with dead-time blanking and a
// one-entry image buffer committed at frame boundaries.
module seven_seg_scan #(
  parameter int unsigned REFRESH_DIV  = 25000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [3:0]  anode_n,
  output logic [7:0]  seven_seg_n,
  output logic        frame_start
);
  import simon_pkg::*;

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  image_t           active_q, pending_q, load_img_c;
  logic             pending_full_q, pending_full_d;
  logic             load_ready_q;
  logic [3:0]       anode_q, anode_d;
  logic [7:0]       seg_q, seg_d;
  logic             fs_q, fs_d;
  logic             wrap_c, accept_c, commit_c;
  logic [3:0]       nibble_c;
  logic [6:0]       dec_seg_c;

  assign load_img_c = '{value: value, digit_en: digit_en, dp: dp};
  assign nibble_c   = active_q.value[{idx_q, 2'b00} +: 4];

  seven_seg u_dec (
    .hex_i   (nibble_c),
    .seg_n_c (dec_seg_c)
  );

  // Slot sequencing and the output image the registers will present next cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    wrap_c  = 1'b0;
    anode_d = ANODE_OFF;
    seg_d   = SEG_OFF;
    fs_d    = 1'b0;
    unique case (state_q)
      ST_BLANK: begin
        fs_d = (idx_q == '0) && (cnt_q == '0);
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (active_q.digit_en[idx_q]) begin
          anode_d[idx_q] = 1'b0;
          seg_d          = {~active_q.dp[idx_q], dec_seg_c};
        end
        if (cnt_q == SLOT_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 1'b1;
          wrap_c  = (idx_q == IDX_LAST);
        end
      end
    endcase
  end

  // Accept only into an empty buffer, so commit and accept never collide
  assign accept_c       = load_valid && load_ready_q;
  assign commit_c       = wrap_c && pending_full_q;
  assign pending_full_d = (pending_full_q && !commit_c) || accept_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_BLANK;
      cnt_q          <= '0;
      idx_q          <= '0;
      active_q       <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      load_ready_q   <= 1'b1;
      anode_q        <= ANODE_OFF;
      seg_q          <= SEG_OFF;
      fs_q           <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      pending_full_q <= pending_full_d;
      load_ready_q   <= ~pending_full_d;
      anode_q        <= anode_d;
      seg_q          <= seg_d;
      fs_q           <= fs_d;
      if (commit_c) begin
        active_q <= pending_q;
      end
      if (accept_c) begin
        pending_q <= load_img_c;
      end
    end
  end

  assign load_ready  = load_ready_q;
  assign anode_n     = anode_q;
  assign seven_seg_n = seg_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan: image table, frame-position model
// feeding a scoreboard queue, plus hand sequences for stall and mid-slot reset.
module tb_seven_seg_scan;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 4 * SLOT;

  typedef struct packed {
    logic [15:0]     value;
    logic [3:0]      en;
    logic [3:0]      dp;
    logic [3:0][7:0] seg;
  } vec_t;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       fs;
    logic       rdy;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  digit_en;
  logic [3:0]  dp;
  logic        load_valid;
  logic        load_ready;
  logic [3:0]  anode_n;
  logic [7:0]  seven_seg_n;
  logic        frame_start;

  vec_t tbl [6];
  exp_t sb_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  int   pos_m, act_m, pend_m, cur_idx, acc_cnt;
  bit   pend_full_m, m_acc;
  int   m_d, m_r;
  exp_t m_e, c_e;

  seven_seg_scan #(.REFRESH_DIV(SLOT), .BLANK_CYCLES(BLANK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .digit_en    (digit_en),
    .dp          (dp),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .anode_n     (anode_n),
    .seven_seg_n (seven_seg_n),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [15:0] v, input logic [3:0] e,
                               input logic [3:0] d, input logic [31:0] s);
    vec_t r;
    r.value = v;
    r.en    = e;
    r.dp    = d;
    r.seg   = s;
    return r;
  endfunction

  // Frame-position model: predicts the registered outputs after each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_m       = 0;
      act_m       = 0;
      pend_m      = 0;
      pend_full_m = 1'b0;
      sb_q.delete();
    end else begin
      m_d      = pos_m / SLOT;
      m_r      = pos_m % SLOT;
      m_e.an   = 4'hF;
      m_e.seg  = 8'hFF;
      m_e.fs   = (pos_m == 0);
      if (m_r >= BLANK && tbl[act_m].en[m_d]) begin
        m_e.an[m_d] = 1'b0;
        m_e.seg     = tbl[act_m].seg[m_d];
      end
      m_acc = load_valid && !pend_full_m;
      if (pos_m == FRAME - 1 && pend_full_m) begin
        act_m       = pend_m;
        pend_full_m = 1'b0;
      end
      if (m_acc) begin
        pend_m      = cur_idx;
        pend_full_m = 1'b1;
        acc_cnt++;
      end
      m_e.rdy = !pend_full_m;
      pos_m   = (pos_m + 1) % FRAME;
      sb_q.push_back(m_e);
    end
  end

  always @(negedge clk) begin
    if (rst_n && sb_q.size() > 0) begin
      c_e = sb_q.pop_front();
      chk("anode_n",     16'(anode_n),     16'(c_e.an));
      chk("seven_seg_n", 16'(seven_seg_n), 16'(c_e.seg));
      chk("frame_start", 16'(frame_start), 16'(c_e.fs));
      chk("load_ready",  16'(load_ready),  16'(c_e.rdy));
    end
  end

  // Present table image i until accepted; optionally keep valid asserted
  task automatic load_img(input int i, input bit keep);
    int a0;
    int n;
    a0         = acc_cnt;
    value      = tbl[i].value;
    digit_en   = tbl[i].en;
    dp         = tbl[i].dp;
    cur_idx    = i;
    load_valid = 1'b1;
    n = 0;
    while (acc_cnt == a0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!keep) load_valid = 1'b0;
    if (acc_cnt == a0) begin
      n_cmp++;
      n_err++;
      $display("FAIL load_accept_timeout image %0d", i);
    end
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    while (pos_m != p && n < 2 * FRAME) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    tbl[0] = mkv(16'h0000, 4'h0, 4'h0, 32'hFFFFFFFF);
    tbl[1] = mkv(16'h1234, 4'hF, 4'h0, 32'hF9A4B099);
    tbl[2] = mkv(16'h0000, 4'h5, 4'h1, 32'hFFC0FF40);
    tbl[3] = mkv(16'h89AB, 4'hF, 4'h0, 32'h80908883);
    tbl[4] = mkv(16'hCDEF, 4'hF, 4'hA, 32'h46A1068E);
    tbl[5] = mkv(16'h0765, 4'hE, 4'h4, 32'hC07882FF);

    rst_n = 1'b1; load_valid = 1'b0; value = '0; digit_en = '0; dp = '0;
    cur_idx = 0; acc_cnt = 0;

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_anode",  16'(anode_n),     16'hF);
    chk("rst_seg",    16'(seven_seg_n), 16'hFF);
    chk("rst_ready",  16'(load_ready),  16'h1);
    chk("rst_fstart", 16'(frame_start), 16'h0);

    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_frame_start", 16'(frame_start), 16'h1);

    // Each table image, shown for at least one full frame
    for (int i = 1; i < 6; i++) begin
      load_img(i, 1'b0);
      repeat (FRAME + 8) @(posedge clk);
      #1;
    end

    // Back-to-back loads with valid held: second stalls until the commit
    load_img(3, 1'b1);
    chk("stall_ready", 16'(load_ready), 16'h0);
    load_img(4, 1'b0);
    repeat (2 * FRAME + 16) @(posedge clk);
    #1;

    // Reset in the middle of a DRIVE slot with an image pending
    wait_pos(2);
    load_img(5, 1'b0);
    wait_pos(13);
    chk("pre_reset_anode", 16'(anode_n), 16'hD);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_anode",  16'(anode_n),     16'hF);
    chk("midrst_seg",    16'(seven_seg_n), 16'hFF);
    chk("midrst_ready",  16'(load_ready),  16'h1);
    chk("midrst_fstart", 16'(frame_start), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME + 4) @(posedge clk);

    // Free run: frame_start period measured on the DUT
    @(negedge clk);
    n = 0;
    while (frame_start !== 1'b1 && n < FRAME + 8) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < FRAME + 8);
    chk("frame_period", 16'(n), 16'(FRAME));
    repeat (100) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
